// File: rtl/data_mem_responder_if.sv
// Processor data-port bundle: request level signals in, registered
// completion strobe, error flag and read data out.
interface data_mem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read_ctrlsig;
  logic        mem_write_ctrlsig;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output data_addr, data_in, mem_read_ctrlsig, mem_write_ctrlsig,
    input  data_out, mem_ready, mem_error
  );

  modport slave (
    input  data_addr, data_in, mem_read_ctrlsig, mem_write_ctrlsig,
    output data_out, mem_ready, mem_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: latches a request in IDLE, waits WAIT_CYCLES
// in BUSY, performs the word access and strobes mem_ready for one cycle
// (DONE). Misaligned, out-of-range and read+write requests complete with
// mem_error and leave storage untouched.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  pc_reset,
  data_mem_responder_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] dout_q, dout_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        mem_we;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          acc_err;

  // Word index and error decode work only on the latched request, so
  // input changes during BUSY cannot disturb the in-flight access.
  assign idx     = addr_q[AW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIM) || (rd_q && wr_q);

  // Next-state, request latching and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read_ctrlsig || bus.mem_write_ctrlsig) begin
          addr_d  = bus.data_addr;
          wdata_d = bus.data_in;
          rd_d    = bus.mem_read_ctrlsig;
          wr_d    = bus.mem_write_ctrlsig;
          cnt_d   = WAIT_LD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          error_d = acc_err;
          if (acc_err)   dout_d = 32'd0;
          else if (rd_q) dout_d = mem[idx];
          mem_we  = wr_q && !acc_err;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any same-edge request.
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Storage is not reset; a write due on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!pc_reset && mem_we) mem[idx] <= wdata_q;
  end

  assign bus.data_out  = dout_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_error = error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: expected completions are queued when a request is
// driven and checked when mem_ready is seen. A second instance with no
// wait states covers the held-request case.
module tb_data_mem_responder;
  localparam int W = 2;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic pc_reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  logic [31:0] mdl [int];
  logic [31:0] mdl_dout = 32'd0;

  data_mem_responder_if bus2();
  data_mem_responder_if bus0();

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .pc_reset(pc_reset), .bus(bus2.slave)
  );
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .pc_reset(pc_reset), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard side: every strobe must match the oldest queued result;
  // outside a strobe the error flag must be low.
  always @(negedge clk) begin
    if (bus2.mem_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("data_out", bus2.data_out, e.dout);
        chk("mem_error", {31'd0, bus2.mem_error}, {31'd0, e.err});
      end
    end else begin
      chk("err_idle", {31'd0, bus2.mem_error}, 32'd0);
    end
  end

  // One access on the WAIT=2 instance; na/nd are driven onto the bus
  // right after acceptance to show the latched request is used.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] na, input logic [31:0] nd);
    exp_t e;
    int   k;
    logic err;
    @(negedge clk);
    bus2.data_addr = a;
    bus2.data_in = d;
    bus2.mem_read_ctrlsig = rd;
    bus2.mem_write_ctrlsig = wr;
    err = (a[1:0] != 2'b00) || (a >= 32'd1024) || (rd && wr);
    if (err) mdl_dout = 32'd0;
    else if (rd) mdl_dout = mdl.exists(int'(a >> 2)) ? mdl[int'(a >> 2)] : 32'hx;
    else mdl[int'(a >> 2)] = d;
    e.dout = mdl_dout;
    e.err = err;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus2.mem_read_ctrlsig = 1'b0;
    bus2.mem_write_ctrlsig = 1'b0;
    bus2.data_addr = na;
    bus2.data_in = nd;
    k = 1;
    while (bus2.mem_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("timeout", 32'd0, 32'd1);
    else chk("latency", 32'(k - 1), 32'(W + 1));
  endtask

  initial begin
    int first;
    int last;
    int npulse;
    logic prev;
    bus2.data_addr = '0; bus2.data_in = '0;
    bus2.mem_read_ctrlsig = 1'b0; bus2.mem_write_ctrlsig = 1'b0;
    bus0.data_addr = '0; bus0.data_in = '0;
    bus0.mem_read_ctrlsig = 1'b0; bus0.mem_write_ctrlsig = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk) pc_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_dout", bus2.data_out, 32'd0);
      chk("rst_ready", {31'd0, bus2.mem_ready}, 32'd0);
    end

    // Basic write/read.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0);

    // Error cases.
    access(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h400, 32'h55555555, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    access(1'b1, 1'b1, 32'h10, 32'h77777777, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h3FC, 32'hFEEDFACE, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h3FC, 32'h0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0);

    // Input change mid-access.
    access(1'b0, 1'b1, 32'h24, 32'h24242424, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h24, 32'hFFFFFFFF);
    access(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h24, 32'h0, 32'h0, 32'h0);

    // Reset in BUSY discards the write and clears outputs.
    access(1'b0, 1'b1, 32'h8, 32'h11111111, 32'h0, 32'h0);
    @(negedge clk);
    bus2.data_addr = 32'h8; bus2.data_in = 32'hAAAA5555;
    bus2.mem_write_ctrlsig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.mem_write_ctrlsig = 1'b0;
    pc_reset = 1'b1;
    @(negedge clk);
    pc_reset = 1'b0;
    mdl_dout = 32'd0;
    chk("rst_busy_dout", bus2.data_out, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy_ready", {31'd0, bus2.mem_ready}, 32'd0);
    end
    access(1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0);

    // Held read on the zero-wait instance: DONE, then IDLE, then the
    // re-accept edge, so strobes recur every third cycle, each one wide.
    @(negedge clk);
    bus0.data_addr = 32'h40; bus0.data_in = 32'hCAFEF00D;
    bus0.mem_write_ctrlsig = 1'b1;
    @(negedge clk);
    bus0.mem_write_ctrlsig = 1'b0;
    repeat (3) @(negedge clk);
    bus0.mem_read_ctrlsig = 1'b1;
    first = -1; last = -1; npulse = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.mem_ready === 1'b1) begin
        chk("held_dout", bus0.data_out, 32'hCAFEF00D);
        chk("held_err", {31'd0, bus0.mem_error}, 32'd0);
        chk("held_width", {31'd0, prev}, 32'd0);
        if (first < 0) first = i;
        else chk("held_gap", 32'(i - last), 32'd3);
        last = i;
        npulse++;
      end
      prev = bus0.mem_ready;
    end
    bus0.mem_read_ctrlsig = 1'b0;
    chk("held_first", 32'(first), 32'd1);
    chk("held_count", 32'(npulse), 32'd7);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
